// File: rtl/wb_pkg.sv
// Shared definitions for the write-back stage: data/register widths and FSM state type.
package wb_pkg;

    localparam int DATA_W   = 32;
    localparam int REG_AW   = 4;
    localparam int NUM_REGS = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } wb_state_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Register busy tracker: a bit per register, set at issue and cleared when its write retires.
module wb_scoreboard #(
    parameter int REG_AW   = 4,
    parameter int NUM_REGS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic [REG_AW-1:0] issue_dest,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_dest,
    input  logic [REG_AW-1:0] chk_src1,
    input  logic [REG_AW-1:0] chk_src2,
    input  logic              chk_src1_en,
    input  logic              chk_src2_en,
    output logic              hazard
);

    logic [NUM_REGS-1:0] busy;

    // Set is applied after clear so a new issue to a retiring register keeps it busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            if (wb_en)
                busy[wb_dest] <= 1'b0;
            if (issue_valid)
                busy[issue_dest] <= 1'b1;
        end
    end

    assign hazard = (chk_src1_en && busy[chk_src1]) || (chk_src2_en && busy[chk_src2]);

endmodule

// File: rtl/writeback_unit.sv
// Write-back stage driving the single register-file write port; dual writes are serialized.
// Optional register scoreboard built when WB_SCOREBOARD_EN is defined.
module writeback_unit #(
    parameter int DATA_W = wb_pkg::DATA_W,
    parameter int REG_AW = wb_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_wb_en,
    input  logic              in_mem_r_en,
    input  logic [REG_AW-1:0] in_dest,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_mem_data,
    input  logic              in_wb2_en,
    input  logic [REG_AW-1:0] in_dest2,
    input  logic              issue_valid,
    input  logic [REG_AW-1:0] issue_dest,
    input  logic [REG_AW-1:0] chk_src1,
    input  logic [REG_AW-1:0] chk_src2,
    input  logic              chk_src1_en,
    input  logic              chk_src2_en,
    output logic              hazard,
    output logic [REG_AW-1:0] Dest_wb,
    output logic [DATA_W-1:0] Result_WB,
    output logic              writeBackEn
);

    import wb_pkg::*;

    wb_state_t         state;
    wb_state_t         next_state;
    logic              accept;
    logic [DATA_W-1:0] primary;
    logic              wr_en;
    logic [REG_AW-1:0] wr_dest;
    logic [DATA_W-1:0] wr_data;
    logic              latch_second;
    logic [REG_AW-1:0] dest2_p0;
    logic [DATA_W-1:0] data2_p0;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;
    assign primary  = in_mem_r_en ? in_mem_data : in_alu_result;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept && in_wb_en && in_wb2_en) next_state = SECOND;
            SECOND:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // A lone base update takes the port directly; only true dual writes defer to SECOND.
    always_comb begin
        wr_en        = 1'b0;
        wr_dest      = in_dest;
        wr_data      = primary;
        latch_second = 1'b0;
        case (state)
            IDLE: begin
                if (accept && in_wb_en) begin
                    wr_en        = 1'b1;
                    latch_second = in_wb2_en;
                end else if (accept && in_wb2_en) begin
                    wr_en   = 1'b1;
                    wr_dest = in_dest2;
                    wr_data = in_alu_result;
                end
            end
            SECOND: begin
                wr_en   = 1'b1;
                wr_dest = dest2_p0;
                wr_data = data2_p0;
            end
            default: ;
        endcase
    end

    // Second-write holding stage; validity is carried by the FSM state.
    always_ff @(posedge clk) begin
        if (latch_second) begin
            dest2_p0 <= in_dest2;
            data2_p0 <= in_alu_result;
        end
    end

    // Register-file port stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            writeBackEn <= 1'b0;
            Dest_wb     <= '0;
            Result_WB   <= '0;
        end else begin
            writeBackEn <= wr_en;
            if (wr_en) begin
                Dest_wb   <= wr_dest;
                Result_WB <= wr_data;
            end
        end
    end

`ifdef WB_SCOREBOARD_EN
    wb_scoreboard #(
        .REG_AW   (REG_AW),
        .NUM_REGS (1 << REG_AW)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_dest  (issue_dest),
        .wb_en       (writeBackEn),
        .wb_dest     (Dest_wb),
        .chk_src1    (chk_src1),
        .chk_src2    (chk_src2),
        .chk_src1_en (chk_src1_en),
        .chk_src2_en (chk_src2_en),
        .hazard      (hazard)
    );
`else
    logic unused_sb_inputs;
    assign unused_sb_inputs = ^{issue_valid, issue_dest, chk_src1, chk_src2, chk_src1_en, chk_src2_en};
    assign hazard = 1'b0;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard-driven bench for writeback_unit; hazard expectations follow WB_SCOREBOARD_EN.
module tb_writeback_unit;

`ifdef WB_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_wb_en, in_mem_r_en, in_wb2_en;
    logic [3:0]  in_dest, in_dest2, issue_dest, chk_src1, chk_src2, Dest_wb;
    logic [31:0] in_alu_result, in_mem_data, Result_WB;
    logic        issue_valid, chk_src1_en, chk_src2_en, hazard, writeBackEn;

    int checks   = 0;
    int failures = 0;
    logic [35:0] exp_q[$];

    writeback_unit dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_wb_en      (in_wb_en),
        .in_mem_r_en   (in_mem_r_en),
        .in_dest       (in_dest),
        .in_alu_result (in_alu_result),
        .in_mem_data   (in_mem_data),
        .in_wb2_en     (in_wb2_en),
        .in_dest2      (in_dest2),
        .issue_valid   (issue_valid),
        .issue_dest    (issue_dest),
        .chk_src1      (chk_src1),
        .chk_src2      (chk_src2),
        .chk_src1_en   (chk_src1_en),
        .chk_src2_en   (chk_src2_en),
        .hazard        (hazard),
        .Dest_wb       (Dest_wb),
        .Result_WB     (Result_WB),
        .writeBackEn   (writeBackEn)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Every register-file write is popped against the queue at the falling edge.
    always @(negedge clk) begin
        if (!rst && writeBackEn) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {Dest_wb, Result_WB}, 36'h0);
            end else begin
                logic [35:0] e;
                e = exp_q.pop_front();
                check("wb_dest", Dest_wb, e[35:32]);
                check("wb_data", Result_WB, e[31:0]);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input bit wb, input bit mr, input logic [3:0] d,
                        input logic [31:0] alu, input logic [31:0] mem,
                        input bit wb2, input logic [3:0] d2, input bit push,
                        output int waits);
        in_valid      = 1'b1;
        in_wb_en      = wb;
        in_mem_r_en   = mr;
        in_dest       = d;
        in_alu_result = alu;
        in_mem_data   = mem;
        in_wb2_en     = wb2;
        in_dest2      = d2;
        if (push && wb)  exp_q.push_back({d, mr ? mem : alu});
        if (push && wb2) exp_q.push_back({d2, alu});
        waits = 0;
        while (!in_ready && waits < 8) begin
            @(posedge clk); #1;
            waits++;
        end
        if (waits >= 8) check("accept_timeout", waits, 0);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        in_wb_en  = 1'b0;
        in_wb2_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        int w;
        rst = 1'b1;
        in_valid = 0; in_wb_en = 0; in_mem_r_en = 0; in_wb2_en = 0;
        in_dest = 0; in_dest2 = 0; in_alu_result = 0; in_mem_data = 0;
        issue_valid = 0; issue_dest = 0; chk_src1 = 0; chk_src2 = 0;
        chk_src1_en = 0; chk_src2_en = 0;
        #2;
        check("rst_wben", writeBackEn, 0);
        check("rst_dest", Dest_wb, 0);
        check("rst_result", Result_WB, 0);
        check("rst_ready", in_ready, 1);
        check("rst_hazard", hazard, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        idle(1);

        // ALU write with single-cycle latency
        send(1, 0, 4'd3, 32'h12345678, 32'h0, 0, 4'd0, 1, w);
        check("alu_wben", writeBackEn, 1);
        check("alu_dest", Dest_wb, 3);
        check("alu_data", Result_WB, 32'h12345678);
        idle(1);
        check("wben_one_cycle", writeBackEn, 0);

        // Load selects memory data
        send(1, 1, 4'd5, 32'h100, 32'hDEADBEEF, 0, 4'd0, 1, w);
        check("load_data", Result_WB, 32'hDEADBEEF);

        // Dual write, with the next instruction held during the stall
        send(1, 1, 4'd2, 32'h204, 32'hAA, 1, 4'd4, 1, w);
        check("dual_ready_low", in_ready, 0);
        check("dual_primary_dest", Dest_wb, 2);
        send(1, 0, 4'd9, 32'h99, 32'h0, 0, 4'd0, 1, w);
        check("held_waits", w, 1);
        check("held_dest", Dest_wb, 9);

        // Back-to-back single writes: full throughput
        send(1, 0, 4'd10, 32'hA0A0, 32'h0, 0, 4'd0, 1, w);
        check("b2b_waits0", w, 0);
        send(1, 0, 4'd11, 32'hB1B1, 32'h0, 0, 4'd0, 1, w);
        check("b2b_waits1", w, 0);
        check("b2b_wben", writeBackEn, 1);

        // Base update alone goes out immediately
        send(0, 0, 4'd1, 32'h300, 32'h0, 1, 4'd12, 1, w);
        check("wb2_only_dest", Dest_wb, 12);
        check("wb2_only_ready", in_ready, 1);

        // Neither enable: no write, outputs hold
        send(0, 1, 4'd7, 32'h777, 32'h888, 0, 4'd8, 1, w);
        check("none_wben", writeBackEn, 0);
        check("none_dest_hold", Dest_wb, 12);
        check("none_data_hold", Result_WB, 32'h300);

        // Same register twice: base update lands last
        send(1, 1, 4'd6, 32'h600, 32'h66, 1, 4'd6, 1, w);
        idle(2);

        // Scoreboard set, source gating, clear on write
        issue_valid = 1; issue_dest = 4'd7;
        idle(1);
        issue_valid = 0;
        chk_src1 = 4'd7; chk_src1_en = 1;
        #1 check("hz_set", hazard, SB);
        chk_src1_en = 0; chk_src2 = 4'd7; chk_src2_en = 1;
        #1 check("hz_src2", hazard, SB);
        chk_src2_en = 0;
        #1 check("hz_disabled", hazard, 0);
        chk_src1_en = 1;
        send(1, 0, 4'd7, 32'h70, 32'h0, 0, 4'd0, 1, w);
        check("hz_during_write", hazard, SB);
        idle(1);
        check("hz_cleared", hazard, 0);

        // Set and clear of R7 on the same edge
        issue_valid = 1; issue_dest = 4'd7;
        idle(1);
        issue_valid = 0;
        send(1, 0, 4'd7, 32'h71, 32'h0, 0, 4'd0, 1, w);
        issue_valid = 1; issue_dest = 4'd7;
        idle(1);
        issue_valid = 0;
        check("hz_set_wins", hazard, SB);
        send(1, 0, 4'd7, 32'h72, 32'h0, 0, 4'd0, 1, w);
        idle(1);
        check("hz_cleared2", hazard, 0);

        // Reset during SECOND discards the pending second write
        issue_valid = 1; issue_dest = 4'd9;
        idle(1);
        issue_valid = 0;
        chk_src1 = 4'd9;
        #1 check("hz_pre_reset", hazard, SB);
        send(1, 0, 4'd2, 32'h2FF, 32'h0, 1, 4'd4, 0, w);
        check("pre_reset_wben", writeBackEn, 1);
        check("pre_reset_ready", in_ready, 0);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_wben", writeBackEn, 0);
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_hazard", hazard, 0);
        check("mid_rst_dest", Dest_wb, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(3);
        check("post_rst_wben", writeBackEn, 0);
        check("post_rst_ready", in_ready, 1);

        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
